// File: rtl/fechadura_pkg.sv
// Shared types for the door-lock controller: lock states and the seconds type
// used by the relock, door-open and lockout timers.
package fechadura_pkg;

   typedef enum logic [2:0] {
      TRAVADA,
      DESTRAVADA,
      ABERTA,
      ALARME,
      BLOQUEADA
   } estado_tranca_t;

   typedef logic [5:0] segundos_t;

   // A configured time of zero seconds behaves as one second.
   function automatic segundos_t min_um(input segundos_t s);
      return (s == segundos_t'(0)) ? segundos_t'(1) : s;
   endfunction

endpackage

// File: rtl/prescaler_seg.sv
// One-second tick generator: counts TICK_CYCLES clocks and pulses tick on the
// last one. clr restarts the count so a freshly loaded timer gets full seconds.
module prescaler_seg #(
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [W-1:0] ULTIMO = W'(TICK_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || (cnt == ULTIMO)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == ULTIMO);

endmodule

// File: rtl/controle_tranca.sv
// Lock actuator / buzzer sequencer: turns PIN verdicts, the inside button and
// the door contact into bolt, buzzer and keypad-lockout outputs.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   TRAVADA    | bolt engaged, waiting for PIN or button
//   DESTRAVADA | bolt released, door still closed, auto-relock timer
//   ABERTA     | door open, door-open alarm timer running
//   ALARME     | door left open too long, buzzer on until it closes
//   BLOQUEADA  | too many wrong PINs, keypad ignored for LOCKOUT_S
module controle_tranca
   import fechadura_pkg::*;
#(
   parameter int TICK_CYCLES     = 50_000_000,
   parameter int MAX_FAILS       = 3,
   parameter int LOCKOUT_S       = 30,
   parameter int FAIL_BIP_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       senha_ok,
   input  logic       senha_fail,
   input  logic       botao_interno,
   input  logic       sensor_de_contato,
   input  logic       cfg_bip_on,
   input  logic [5:0] cfg_tempo_tranca,
   input  logic [5:0] cfg_tempo_bip,
   output logic       tranca,
   output logic       bip,
   output logic       bloqueado
);

   localparam int            BW         = $clog2(FAIL_BIP_CYCLES + 1);
   localparam logic [3:0]    FALHAS_MAX = 4'(MAX_FAILS);
   localparam segundos_t     T_BLOQUEIO = segundos_t'(LOCKOUT_S);
   localparam logic [BW-1:0] BIP_CARGA  = BW'(FAIL_BIP_CYCLES);

   estado_tranca_t estado, estado_prox;
   segundos_t      timer, timer_prox, carga_valor;
   logic [3:0]     falhas, falhas_prox, falhas_sat;
   logic [BW-1:0]  bip_cnt, bip_cnt_prox;
   logic           botao_reg, botao_ant, botao_borda;
   logic           carga, aceita_falha, tick, expira;

   prescaler_seg #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (carga),
      .tick (tick)
   );

   assign botao_borda = botao_reg & ~botao_ant;
   assign expira      = tick && (timer == segundos_t'(1));
   assign falhas_sat  = (falhas >= FALHAS_MAX) ? FALHAS_MAX : falhas + 4'd1;

   // Each branch of the if-chains encodes the event priority; a lower-priority
   // event in the same cycle is dropped.
   always_comb begin
      estado_prox  = estado;
      carga        = 1'b0;
      carga_valor  = '0;
      falhas_prox  = falhas;
      aceita_falha = 1'b0;

      case (estado)
         TRAVADA: begin
            if (botao_borda) begin
               estado_prox = DESTRAVADA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
            end else if (senha_ok) begin
               estado_prox = DESTRAVADA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
               falhas_prox = '0;
            end else if (senha_fail) begin
               aceita_falha = 1'b1;
               falhas_prox  = falhas_sat;
               if (falhas_sat == FALHAS_MAX) begin
                  estado_prox = BLOQUEADA;
                  carga       = 1'b1;
                  carga_valor = T_BLOQUEIO;
                  falhas_prox = '0;
               end
            end
         end
         DESTRAVADA: begin
            if (!sensor_de_contato) begin
               estado_prox = ABERTA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_bip);
            end else if (botao_borda) begin
               estado_prox = TRAVADA;
            end else if (senha_ok) begin
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
               falhas_prox = '0;
            end else begin
               // A wrong PIN while unlocked only counts and beeps.
               if (senha_fail) begin
                  aceita_falha = 1'b1;
                  falhas_prox  = falhas_sat;
               end
               if (expira) begin
                  estado_prox = TRAVADA;
               end
            end
         end
         ABERTA: begin
            if (sensor_de_contato) begin
               estado_prox = DESTRAVADA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
            end else if (expira && cfg_bip_on) begin
               estado_prox = ALARME;
            end
         end
         ALARME: begin
            if (sensor_de_contato) begin
               estado_prox = DESTRAVADA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
            end
         end
         BLOQUEADA: begin
            if (botao_borda) begin
               estado_prox = DESTRAVADA;
               carga       = 1'b1;
               carga_valor = min_um(cfg_tempo_tranca);
            end else if (expira) begin
               estado_prox = TRAVADA;
            end
         end
         default: begin
            estado_prox = TRAVADA;
         end
      endcase

      if (carga) begin
         timer_prox = carga_valor;
      end else if (tick && (timer != segundos_t'(0))) begin
         timer_prox = timer - segundos_t'(1);
      end else begin
         timer_prox = timer;
      end

      if (aceita_falha) begin
         bip_cnt_prox = BIP_CARGA;
      end else if (bip_cnt != '0) begin
         bip_cnt_prox = bip_cnt - 1'b1;
      end else begin
         bip_cnt_prox = bip_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado    <= TRAVADA;
         timer     <= '0;
         falhas    <= '0;
         bip_cnt   <= '0;
         botao_reg <= 1'b0;
         botao_ant <= 1'b0;
         tranca    <= 1'b1;
         bip       <= 1'b0;
         bloqueado <= 1'b0;
      end else begin
         estado    <= estado_prox;
         timer     <= timer_prox;
         falhas    <= falhas_prox;
         bip_cnt   <= bip_cnt_prox;
         botao_reg <= botao_interno;
         botao_ant <= botao_reg;
         tranca    <= (estado_prox == TRAVADA) || (estado_prox == BLOQUEADA);
         bip       <= (estado_prox == ALARME) || (bip_cnt_prox != '0);
         bloqueado <= (estado_prox == BLOQUEADA);
      end
   end

endmodule
